sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM (IDLE -> ACCESS -> RDATA).
// Define SRAM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             ram_cs,
    output logic             ram_we,
    output logic             ram_oe,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    state_t           state_q, state_d;
    logic             sel_q, sel_d;      // 0 = port 0 owns the access, 1 = port 1
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             capture;
    logic             in_range;

    assign capture  = (state_q == IDLE) && (req0 || req1);
    // Addresses past DEPTH only exist for non-power-of-2 DEPTH; they get a grant but never strobe the RAM.
    assign in_range = ({1'b0, addr_q} < DEPTH_W);

`ifdef SRAM_ARB_RR_EN
    logic last_q;

    assign sel_d = (req0 && req1) ? ~last_q : ~req0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (capture) begin
            last_q <= sel_d;
        end
    end
`else
    assign sel_d = ~req0;
`endif

    always_comb begin
        wr_d    = sel_d ? wr1 : wr0;
        addr_d  = sel_d ? addr1 : addr0;
        wdata_d = sel_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                sel_q   <= sel_d;
                wr_q    <= wr_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rvalid0  = 1'b0;
        rvalid1  = 1'b0;
        rdata0   = '0;
        rdata1   = '0;
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_oe   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            IDLE: begin
                if (capture) state_d = ACCESS;
            end
            ACCESS: begin
                gnt0     = ~sel_q;
                gnt1     = sel_q;
                ram_cs   = in_range;
                ram_we   = in_range & wr_q;
                ram_oe   = in_range & ~wr_q;
                ram_addr = addr_q;
                ram_din  = wdata_q;
                state_d  = wr_q ? IDLE : RDATA;
            end
            RDATA: begin
                rvalid0 = ~sel_q;
                rvalid1 = sel_q;
                if (!sel_q) rdata0 = in_range ? ram_dout : '0;
                else        rdata1 = in_range ? ram_dout : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (DEPTH = 20 so out-of-range addresses exist).
// Expected data comes from a word-array reference memory and a last-winner arbitration model.
module tb_sram_arbiter;

    localparam int WIDTH = 4;
    localparam int DEPTH = 20;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, wr0, wr1;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             ram_cs, ram_we, ram_oe;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               last_gnt;

    logic [WIDTH-1:0] sram [DEPTH];

    sram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: registered read data, valid the cycle after cs&oe.
    always @(posedge clk) begin
        if (ram_cs && ram_we) sram[ram_addr] <= ram_din;
        if (ram_cs && ram_oe) ram_dout <= sram[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        if (p == 0) begin
            req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        check({tag, "_strobe"}, {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        check({tag, "_rdata"},  {24'd0, rdata1, rdata0}, 32'd0);
    endtask

    // One complete access from IDLE: request, grant + strobe, optional read data, back to IDLE.
    task automatic access(input int p, input bit w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bit               inr;
        logic [WIDTH-1:0] exp_rd;
        inr    = (int'(a) < DEPTH);
        exp_rd = inr ? ref_mem[a] : '0;
        drive(p, w, a, d);
        step();
        check("acc_gnt0", gnt0, p == 0);
        check("acc_gnt1", gnt1, p == 1);
        check("acc_cs",   ram_cs, inr);
        if (inr) begin
            check("acc_we",   ram_we, w);
            check("acc_oe",   ram_oe, !w);
            check("acc_addr", ram_addr, a);
            if (w) check("acc_din", ram_din, d);
        end
        drop(p);
        last_gnt = p;
        if (w && inr) ref_mem[a] = d;
        if (!w) begin
            step();
            check("rd_rvalid0", rvalid0, p == 0);
            check("rd_rvalid1", rvalid1, p == 1);
            check("rd_gnt",     gnt0 | gnt1, 0);
            check("rd_cs",      ram_cs, 0);
            if (p == 0) begin
                check("rd_rdata0", rdata0, exp_rd);
                check("rd_rdata1_idle", rdata1, 0);
            end else begin
                check("rd_rdata1", rdata1, exp_rd);
                check("rd_rdata0_idle", rdata0, 0);
            end
        end
        step();
        check_quiet("acc_idle");
    endtask

    task automatic apply_reset();
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_gnt = 1;
    endtask

    initial begin
        logic [WIDTH-1:0] cd0, cd1, seen_din;
        int               exp_w, n;

        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst = 1'b0;
        #1;
        check_quiet("reset");
        check("reset_addr", ram_addr, 0);
        check("reset_din",  ram_din, 0);
        apply_reset();

        // Write then read back address 5 across the two ports.
        access(0, 1'b1, 5'd5, 4'hA);
        access(1, 1'b0, 5'd5, 4'h0);

        // Populate every in-range word so later reads have known contents.
        for (int i = 0; i < DEPTH; i++) access(i % 2, 1'b1, AW'(i), WIDTH'($urandom));

        // Port 1 arrives while port 0's read is in flight; it waits and port 0 is undisturbed.
        drive(0, 1'b0, 5'd7, 4'h0);
        step();
        check("busy_gnt0", gnt0, 1);
        drop(0);
        cd1 = WIDTH'($urandom);
        drive(1, 1'b1, 5'd8, cd1);
        step();
        check("busy_rvalid0", rvalid0, 1);
        check("busy_rdata0",  rdata0, ref_mem[7]);
        check("busy_gnt1_wait", gnt1, 0);
        step();
        check("busy_gnt1_idle", gnt1, 0);
        step();
        check("busy_gnt1", gnt1, 1);
        check("busy_addr", ram_addr, 8);
        check("busy_din",  ram_din, cd1);
        ref_mem[8] = cd1;
        drop(1);
        last_gnt = 1;
        step();
        check_quiet("busy_done");
        access(1, 1'b0, 5'd8, 4'h0);

        // Reset during the ACCESS cycle of a read aborts it with no replay.
        drive(1, 1'b0, 5'd5, 4'h0);
        step();
        check("rst_pre_cs", ram_cs, 1);
        drop(1);
        #2 rst = 1'b0;
        #1;
        check_quiet("rst_async");
        @(negedge clk);
        rst = 1'b1;
        last_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("rst_after");
        end
        access(0, 1'b0, 5'd5, 4'h0);

        // Out-of-range addresses: grant without a RAM strobe, reads return zero.
        access(0, 1'b0, 5'd25, 4'h0);
        access(1, 1'b1, 5'd22, 4'h7);
        access(1, 1'b0, 5'd20, 4'h0);

        // Contention right after reset: both ports hold req for six grants.
        apply_reset();
        cd0 = WIDTH'($urandom);
        cd1 = WIDTH'($urandom);
        drive(0, 1'b1, 5'd3, cd0);
        drive(1, 1'b1, 5'd4, cd1);
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(gnt0 || gnt1) && n < 4);
`ifdef SRAM_ARB_RR_EN
            exp_w = 1 - last_gnt;
`else
            exp_w = 0;
`endif
            check("cont_gnt_seen",   gnt0 | gnt1, 1);
            check("cont_gnt_onehot", gnt0 & gnt1, 0);
            check("cont_winner",     gnt1, exp_w == 1);
            seen_din = (exp_w == 1) ? cd1 : cd0;
            check("cont_din", ram_din, seen_din);
            ref_mem[(exp_w == 1) ? 4 : 3] = seen_din;
            last_gnt = exp_w;
            if (exp_w == 1) begin cd1 = WIDTH'($urandom); wdata1 = cd1; end
            else            begin cd0 = WIDTH'($urandom); wdata0 = cd0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        check_quiet("cont_done");
        access(0, 1'b0, 5'd3, 4'h0);
        access(1, 1'b0, 5'd4, 4'h0);

        // Randomized single-requester traffic, including out-of-range addresses.
        for (int i = 0; i < 40; i++)
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 24)), WIDTH'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
